// File: rtl/qmac_accum.sv
// Signed Q-format product accumulator with valid/ready streams in and out and a sticky overflow flag.
// Optional build macro QMAC_SATURATE_EN clamps out-of-range sums instead of wrapping them.
module qmac_accum #(
    parameter int N  = 16,
    parameter int Q  = 8,
    parameter int LW = 8,
    parameter int G  = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [LW-1:0] i_len,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [N-1:0]  i_product,
    input  logic          i_ovr,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [N-1:0]  o_result,
    output logic          o_ovr,
    output logic          o_busy
);

    localparam int AW = N + G;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [AW-1:0] MAX_EXT = {{(G + 1){1'b0}}, {(N - 1){1'b1}}};
    localparam logic [AW-1:0] MIN_EXT = {{(G + 1){1'b1}}, {(N - 1){1'b0}}};

    // Guard bits must cover the longest sum so the accumulator can never wrap.
    if (G < LW) begin : g_guard_check
        $error("qmac_accum: G must be >= LW");
    end
    if (Q > N) begin : g_frac_check
        $error("qmac_accum: Q must not exceed N");
    end

`ifdef QMAC_SATURATE_EN
    function automatic logic [N-1:0] fit_result(input logic [AW-1:0] s);
        logic [N-1:0] r;
        if ($signed(s) > $signed(MAX_EXT)) begin
            r = {1'b0, {(N - 1){1'b1}}};
        end else if ($signed(s) < $signed(MIN_EXT)) begin
            r = {1'b1, {(N - 1){1'b0}}};
        end else begin
            r = s[N-1:0];
        end
        return r;
    endfunction
`endif

    logic [1:0]    state_r, state_s;
    logic [LW-1:0] len_r, len_s;
    logic [LW-1:0] cnt_r, cnt_s;
    logic [AW-1:0] acc_r, acc_s;
    logic          sticky_r, sticky_s;
    logic          ready_r, valid_r, valid_s, ovr_r, ovr_s, busy_r;
    logic [N-1:0]  result_r, result_s;
    logic          beat_s, range_ovr_s;
    logic [AW-1:0] sum_s;
    logic [N-1:0]  fit_s;
    logic [LW-1:0] last_idx_s;

    // Datapath: running sum including the current product and its range check.
    always_comb begin
        beat_s      = i_valid & ready_r;
        sum_s       = acc_r + {{G{i_product[N-1]}}, i_product};
        range_ovr_s = ($signed(sum_s) > $signed(MAX_EXT)) | ($signed(sum_s) < $signed(MIN_EXT));
        last_idx_s  = len_r - {{(LW - 1){1'b0}}, 1'b1};
`ifdef QMAC_SATURATE_EN
        fit_s       = fit_result(sum_s);
`else
        fit_s       = sum_s[N-1:0];
`endif
    end

    // Control: next-state and next-value selection for every register.
    always_comb begin
        state_s  = state_r;
        len_s    = len_r;
        cnt_s    = cnt_r;
        acc_s    = acc_r;
        sticky_s = sticky_r;
        valid_s  = valid_r;
        result_s = result_r;
        ovr_s    = ovr_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    len_s    = i_len;
                    cnt_s    = {LW{1'b0}};
                    acc_s    = {AW{1'b0}};
                    sticky_s = 1'b0;
                    if (i_len != {LW{1'b0}}) begin
                        state_s = ST_ACCUM;
                    end else begin
                        state_s  = ST_DONE;
                        valid_s  = 1'b1;
                        result_s = {N{1'b0}};
                        ovr_s    = 1'b0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (beat_s) begin
                    acc_s    = sum_s;
                    sticky_s = sticky_r | i_ovr;
                    cnt_s    = cnt_r + {{(LW - 1){1'b0}}, 1'b1};
                    if (cnt_r == last_idx_s) begin
                        state_s  = ST_DONE;
                        valid_s  = 1'b1;
                        result_s = fit_s;
                        ovr_s    = sticky_r | i_ovr | range_ovr_s;
                    end else begin
                        state_s = ST_ACCUM;
                    end
                end else begin
                    state_s = ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_s = ST_IDLE;
                    valid_s = 1'b0;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers; ready/busy are registered decodes of the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r  <= ST_IDLE;
            len_r    <= {LW{1'b0}};
            cnt_r    <= {LW{1'b0}};
            acc_r    <= {AW{1'b0}};
            sticky_r <= 1'b0;
            ready_r  <= 1'b0;
            valid_r  <= 1'b0;
            result_r <= {N{1'b0}};
            ovr_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            len_r    <= len_s;
            cnt_r    <= cnt_s;
            acc_r    <= acc_s;
            sticky_r <= sticky_s;
            ready_r  <= (state_s == ST_ACCUM);
            valid_r  <= valid_s;
            result_r <= result_s;
            ovr_r    <= ovr_s;
            busy_r   <= (state_s != ST_IDLE);
        end
    end

    assign o_ready  = ready_r;
    assign o_valid  = valid_r;
    assign o_result = result_r;
    assign o_ovr    = ovr_r;
    assign o_busy   = busy_r;

endmodule

// File: tb/tb_qmac_accum.sv
// Randomized self-checking bench for qmac_accum against an integer-arithmetic dot-product model.
module tb_qmac_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        valid = 1'b0;
    logic        ready_o;
    logic [15:0] product = 16'd0;
    logic        povr = 1'b0;
    logic        valid_o;
    logic        rdy = 1'b0;
    logic [15:0] result_o;
    logic        ovr_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] prod_q[$];
    logic        ovr_q[$];

    logic [15:0] obs_result;
    logic        obs_ovr, obs_lat_ok, obs_timeout, obs_ready_seen;
    int          obs_beats;

    qmac_accum dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len),
        .i_valid(valid), .o_ready(ready_o), .i_product(product), .i_ovr(povr),
        .o_valid(valid_o), .i_ready(rdy), .o_result(result_o), .o_ovr(ovr_o),
        .o_busy(busy_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Dot product with plain integers, then clamp or wrap into 16 bits.
    task automatic model(input int n, output logic [15:0] r, output logic o);
        longint s = 0;
        o = 1'b0;
        for (int i = 0; i < n; i++) begin
            s += longint'($signed(prod_q[i]));
            o |= ovr_q[i];
        end
        if (s > 32767 || s < -32768) o = 1'b1;
`ifdef QMAC_SATURATE_EN
        if (s > 32767) r = 16'h7FFF;
        else if (s < -32768) r = 16'h8000;
        else r = s[15:0];
`else
        r = s[15:0];
`endif
    endtask

    // Drives one sum (start, then len products with random valid gaps); records observations only.
    task automatic drive_sum(input int n, input int valid_pct);
        int  idx = 0;
        int  guard = 0;
        logic acc;
        obs_beats = 0;
        obs_lat_ok = 1'b0;
        obs_ready_seen = 1'b0;
        start = 1'b1;
        len = n[7:0];
        step();
        start = 1'b0;
        if (n == 0) begin
            obs_lat_ok = valid_o;
            valid = 1'b1;
            product = 16'h1234;
            obs_ready_seen = ready_o;
        end
        while (idx < n && guard < 2000) begin
            valid = ($urandom_range(99) < valid_pct);
            product = prod_q[idx];
            povr = ovr_q[idx];
            acc = valid && ready_o;
            step();
            guard++;
            if (acc) begin
                idx++;
                obs_beats++;
                if (idx == n) obs_lat_ok = valid_o;
            end
        end
        valid = 1'b0;
        povr = 1'b0;
        obs_timeout = (idx < n);
        obs_result = result_o;
        obs_ovr = ovr_o;
    endtask

    task automatic handshake();
        rdy = 1'b1;
        step();
        rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if ({ready_o, valid_o, result_o, ovr_o, busy_o} !== 20'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b val=%b res=%h ovr=%b busy=%b, want all zero",
                     ready_o, valid_o, result_o, ovr_o, busy_o);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [15:0] er;
        logic eo;
        prod_q = '{16'h0180, 16'h0200, 16'hFF00};
        ovr_q = '{1'b0, 1'b0, 1'b0};
        model(3, er, eo);
        drive_sum(3, 100);
        n_cmp++;
        if (obs_lat_ok !== 1'b1 || obs_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_latency: got valid=%b timeout=%b, want 1/0", obs_lat_ok, obs_timeout);
        end
        n_cmp++;
        if (obs_result !== 16'h0280 || obs_result !== er) begin
            n_bad++;
            $display("FAIL basic_result: got %h want %h", obs_result, er);
        end
        n_cmp++;
        if (obs_ovr !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_ovr: got %b want 0", obs_ovr);
        end
        handshake();
    endtask

    task automatic test_overflow();
        logic [15:0] er;
        logic eo;
        prod_q = '{16'h7000, 16'h7000, 16'h7000, 16'h7000};
        ovr_q = '{1'b0, 1'b0, 1'b0, 1'b0};
        model(4, er, eo);
        drive_sum(4, 70);
        n_cmp++;
        if (obs_result !== er || obs_ovr !== 1'b1) begin
            n_bad++;
            $display("FAIL pos_overflow: got res=%h ovr=%b want res=%h ovr=1", obs_result, obs_ovr, er);
        end
        handshake();
        prod_q = '{16'h9000, 16'h9000};
        ovr_q = '{1'b0, 1'b0};
        model(2, er, eo);
        drive_sum(2, 100);
        n_cmp++;
        if (obs_result !== er || obs_ovr !== 1'b1) begin
            n_bad++;
            $display("FAIL neg_overflow: got res=%h ovr=%b want res=%h ovr=1", obs_result, obs_ovr, er);
        end
        handshake();
    endtask

    task automatic test_ovr_flag();
        prod_q = '{16'h0100, 16'h0100};
        ovr_q = '{1'b0, 1'b1};
        drive_sum(2, 100);
        n_cmp++;
        if (obs_result !== 16'h0200 || obs_ovr !== 1'b1) begin
            n_bad++;
            $display("FAIL ovr_propagate: got res=%h ovr=%b want res=0200 ovr=1", obs_result, obs_ovr);
        end
        handshake();
    endtask

    task automatic test_done_hold();
        logic [15:0] er;
        logic eo;
        prod_q = {16'($urandom), 16'($urandom)};
        ovr_q = '{1'b0, 1'b0};
        model(2, er, eo);
        drive_sum(2, 100);
        for (int k = 0; k < 3; k++) begin
            start = 1'b1;
            valid = 1'b1;
            len = 8'd5;
            product = 16'($urandom);
            step();
            n_cmp++;
            if (valid_o !== 1'b1 || result_o !== er || ovr_o !== eo || ready_o !== 1'b0) begin
                n_bad++;
                $display("FAIL done_hold[%0d]: got val=%b res=%h ovr=%b rdy=%b want 1/%h/%b/0",
                         k, valid_o, result_o, ovr_o, ready_o, er, eo);
            end
        end
        start = 1'b0;
        valid = 1'b0;
        handshake();
        n_cmp++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL done_release: got val=%b busy=%b want 0/0", valid_o, busy_o);
        end
        step();
        n_cmp++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_stays: got busy=%b rdy=%b want 0/0", busy_o, ready_o);
        end
    endtask

    task automatic test_len_zero();
        prod_q.delete();
        ovr_q.delete();
        drive_sum(0, 100);
        n_cmp++;
        if (obs_lat_ok !== 1'b1 || obs_result !== 16'h0000 || obs_ovr !== 1'b0 || obs_ready_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL len_zero: got val=%b res=%h ovr=%b rdy=%b want 1/0000/0/0",
                     obs_lat_ok, obs_result, obs_ovr, obs_ready_seen);
        end
        valid = 1'b0;
        handshake();
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        len = 8'd5;
        step();
        start = 1'b0;
        valid = 1'b1;
        product = 16'h0400;
        step();
        step();
        valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({ready_o, valid_o, result_o, ovr_o, busy_o} !== 20'd0) begin
            n_bad++;
            $display("FAIL reset_mid: got rdy=%b val=%b res=%h ovr=%b busy=%b want zero",
                     ready_o, valid_o, result_o, ovr_o, busy_o);
        end
        prod_q = '{16'h0080};
        ovr_q = '{1'b0};
        drive_sum(1, 100);
        n_cmp++;
        if (obs_result !== 16'h0080 || obs_ovr !== 1'b0 || obs_lat_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL after_reset_sum: got res=%h ovr=%b val=%b want 0080/0/1",
                     obs_result, obs_ovr, obs_lat_ok);
        end
        handshake();
    endtask

    // Random sums started in the cycle right after each handshake, plus full-length extremes.
    task automatic test_back_to_back();
        logic [15:0] er;
        logic eo;
        for (int t = 0; t < 26; t++) begin
            int n;
            n = (t == 24 || t == 25) ? 255 : int'($urandom_range(8, 1));
            prod_q.delete();
            ovr_q.delete();
            for (int i = 0; i < n; i++) begin
                if (t == 24) prod_q.push_back(16'h7FFF);
                else if (t == 25) prod_q.push_back(16'h8000);
                else if (t % 3 == 0) prod_q.push_back(16'($urandom));
                else prod_q.push_back(16'($signed(12'($urandom))));
                ovr_q.push_back($urandom_range(19) == 0);
            end
            model(n, er, eo);
            drive_sum(n, (t % 2 == 0) ? 100 : 60);
            n_cmp++;
            if (obs_timeout !== 1'b0 || obs_lat_ok !== 1'b1 || obs_result !== er || obs_ovr !== eo) begin
                n_bad++;
                $display("FAIL rand_sum[%0d] len=%0d: got res=%h ovr=%b val=%b to=%b want %h/%b/1/0",
                         t, n, obs_result, obs_ovr, obs_lat_ok, obs_timeout, er, eo);
            end
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_ovr_flag();
        test_done_hold();
        test_len_zero();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
